// File: rtl/mMaskKron_package.sv
// Shared word layout for heap-resident Bool quadtrees: node word, pointer,
// tag values and child field positions.
package mMaskKron_package;

    localparam int PTR_W  = 16;
    localparam int WORD_W = 67;

    typedef logic [WORD_W-1:0] QTree_Bool_t;
    typedef logic [PTR_W-1:0]  Pointer_QTree_Bool_t;

    typedef enum logic [1:0] {
        TAG_QVAL   = 2'd0,
        TAG_QNONE  = 2'd1,
        TAG_QNODE  = 2'd2,
        TAG_QERROR = 2'd3
    } qtreeTag_t;

    localparam int TAG_LSB    = 1;
    localparam int CHILD1_LSB = 3;
    localparam int CHILD2_LSB = 19;
    localparam int CHILD3_LSB = 35;
    localparam int CHILD4_LSB = 51;

    // Replacement leaf for subtrees that cannot be walked: tag only, payload zero.
    localparam QTree_Bool_t QERROR_WORD = {64'd0, TAG_QERROR, 1'b0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT,
        ST_NEXT
    } serState_t;

    function automatic qtreeTag_t wordTag(input QTree_Bool_t w);
        return qtreeTag_t'(w[TAG_LSB +: 2]);
    endfunction

    // kIdx is the zero-based child number (child k is kIdx = k-1).
    function automatic Pointer_QTree_Bool_t childPtr(input QTree_Bool_t w, input logic [1:0] kIdx);
        case (kIdx)
            2'd0:    return w[CHILD1_LSB +: PTR_W];
            2'd1:    return w[CHILD2_LSB +: PTR_W];
            2'd2:    return w[CHILD3_LSB +: PTR_W];
            default: return w[CHILD4_LSB +: PTR_W];
        endcase
    endfunction

endpackage

// File: rtl/qtree_ser_stack.sv
// LIFO of QNode ancestors, each with a count of children already visited.
module qtree_ser_stack
    import mMaskKron_package::*;
#(
    parameter int STACK_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic [66:0]                        pushWord,
    input  logic                               pop,
    input  logic                               incTop,
    output logic [66:0]                        topWord,
    output logic [2:0]                         topCnt,
    output logic [$clog2(STACK_DEPTH + 1)-1:0] level,
    output logic                               full,
    output logic                               empty
);

    localparam int PW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [66:0]   wordMem [STACK_DEPTH];
    logic [2:0]    cntMem  [STACK_DEPTH];
    logic [PW-1:0] sp;
    logic [IW-1:0] topIdx;
    logic [IW-1:0] pushIdx;

    assign topIdx  = IW'(sp - PW'(1));
    assign pushIdx = IW'(sp);
    assign full    = (sp == PW'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign level   = sp;
    assign topWord = wordMem[topIdx];
    assign topCnt  = cntMem[topIdx];

    // The pointer saturates at both ends rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PW'(1);
        end else if (pop && !empty) begin
            sp <= sp - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            wordMem[pushIdx] <= pushWord;
            cntMem[pushIdx]  <= 3'd0;
        end else if (incTop && !empty) begin
            cntMem[topIdx] <= cntMem[topIdx] + 3'd1;
        end
    end

endmodule

// File: rtl/qtree_bool_serializer.sv
// Walks a Bool quadtree held in a heap and streams its node words in postorder
// (children 4..1, then the node), one heap read outstanding at a time.
module qtree_bool_serializer
    import mMaskKron_package::*;
#(
    parameter int STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] root_d,
    output logic        root_r,
    output logic [14:0] heap_rd_addr,
    output logic        heap_rd_valid,
    input  logic        heap_rd_ready,
    input  logic [66:0] heap_rsp_data,
    input  logic        heap_rsp_valid,
    output logic [66:0] o_QTree_Bool_tdata,
    output logic        o_QTree_Bool_tlast,
    output logic        o_QTree_Bool_tvalid,
    input  logic        o_QTree_Bool_tready,
    output logic        busy,
    output logic        error
);

    localparam int PW = $clog2(STACK_DEPTH + 1);

    serState_t           state;
    logic                stkPush;
    logic                stkPop;
    logic                stkInc;
    logic                stkFull;
    logic                stkEmpty;
    logic [66:0]         stkTopWord;
    logic [2:0]          stkTopCnt;
    logic [PW-1:0]       stkLevel;
    logic                rspIsNode;
    logic                childrenLeft;
    Pointer_QTree_Bool_t nextChild;

    assign rspIsNode    = (wordTag(heap_rsp_data) == TAG_QNODE);
    assign childrenLeft = (stkTopCnt < 3'd4);
    // Visit count 0..3 selects child 4..1.
    assign nextChild    = childPtr(stkTopWord, ~stkTopCnt[1:0]);

    assign stkPush = (state == ST_WAIT) && heap_rsp_valid && rspIsNode && !stkFull;
    assign stkInc  = (state == ST_NEXT) && childrenLeft;
    assign stkPop  = (state == ST_NEXT) && !childrenLeft;

    qtree_ser_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) ancestors (
        .clk      (clk),
        .reset    (reset),
        .push     (stkPush),
        .pushWord (heap_rsp_data),
        .pop      (stkPop),
        .incTop   (stkInc),
        .topWord  (stkTopWord),
        .topCnt   (stkTopCnt),
        .level    (stkLevel),
        .full     (stkFull),
        .empty    (stkEmpty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= ST_IDLE;
            root_r              <= 1'b1;
            heap_rd_addr        <= '0;
            heap_rd_valid       <= 1'b0;
            o_QTree_Bool_tdata  <= '0;
            o_QTree_Bool_tlast  <= 1'b0;
            o_QTree_Bool_tvalid <= 1'b0;
            busy                <= 1'b0;
            error               <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (root_d[0]) begin
                        heap_rd_addr  <= root_d[15:1];
                        heap_rd_valid <= 1'b1;
                        root_r        <= 1'b0;
                        busy          <= 1'b1;
                        state         <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (heap_rd_ready) begin
                        heap_rd_valid <= 1'b0;
                        state         <= ST_WAIT;
                    end
                end
                // A QNode that finds the stack full is emitted as an error leaf.
                ST_WAIT: begin
                    if (heap_rsp_valid) begin
                        if (rspIsNode && !stkFull) begin
                            state <= ST_NEXT;
                        end else begin
                            if (rspIsNode) begin
                                error              <= 1'b1;
                                o_QTree_Bool_tdata <= QERROR_WORD;
                            end else begin
                                o_QTree_Bool_tdata <= heap_rsp_data;
                            end
                            o_QTree_Bool_tlast  <= stkEmpty;
                            o_QTree_Bool_tvalid <= 1'b1;
                            state               <= ST_EMIT;
                        end
                    end
                end
                ST_NEXT: begin
                    if (childrenLeft) begin
                        if (nextChild[0]) begin
                            heap_rd_addr  <= nextChild[15:1];
                            heap_rd_valid <= 1'b1;
                            state         <= ST_FETCH;
                        end else begin
                            error               <= 1'b1;
                            o_QTree_Bool_tdata  <= QERROR_WORD;
                            o_QTree_Bool_tlast  <= 1'b0;
                            o_QTree_Bool_tvalid <= 1'b1;
                            state               <= ST_EMIT;
                        end
                    end else begin
                        o_QTree_Bool_tdata  <= stkTopWord;
                        o_QTree_Bool_tlast  <= (stkLevel == PW'(1));
                        o_QTree_Bool_tvalid <= 1'b1;
                        state               <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (o_QTree_Bool_tready) begin
                        o_QTree_Bool_tvalid <= 1'b0;
                        o_QTree_Bool_tlast  <= 1'b0;
                        if (stkEmpty) begin
                            root_r <= 1'b1;
                            busy   <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end
                end
                default: begin
                    heap_rd_valid       <= 1'b0;
                    o_QTree_Bool_tvalid <= 1'b0;
                    root_r              <= 1'b1;
                    busy                <= 1'b0;
                    state               <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qtree_bool_serializer.sv
// Bench for qtree_bool_serializer: a default-depth and a depth-2 instance share
// one heap model and one stream collector, selected by sel.
module tb_qtree_bool_serializer;

    typedef struct {
        int               scen;
        logic             sel;
        int               readyDelay;
        logic             toggle;
        int               nBeats;
        logic [15:0][67:0] expBeats;
        logic             expErr;
    } vec_t;

    localparam int NVEC = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] rootD = '0;
    logic        rdReady;
    logic        rspValid;
    logic [66:0] rspData;
    logic        tready;

    logic        rootRB, rdValidB, tlastB, tvalidB, busyB, errorB;
    logic [14:0] rdAddrB;
    logic [66:0] tdataB;
    logic        rootRS, rdValidS, tlastS, tvalidS, busyS, errorS;
    logic [14:0] rdAddrS;
    logic [66:0] tdataS;

    logic        rootRM, rdValidM, tlastM, tvalidM, busyM, errorM;
    logic [14:0] rdAddrM;
    logic [66:0] tdataM;

    qtree_bool_serializer #(.STACK_DEPTH(16)) dutBig (
        .clk                 (clk),
        .reset               (reset),
        .root_d              (sel ? 16'h0000 : rootD),
        .root_r              (rootRB),
        .heap_rd_addr        (rdAddrB),
        .heap_rd_valid       (rdValidB),
        .heap_rd_ready       (rdReady && !sel),
        .heap_rsp_data       (rspData),
        .heap_rsp_valid      (rspValid && !sel),
        .o_QTree_Bool_tdata  (tdataB),
        .o_QTree_Bool_tlast  (tlastB),
        .o_QTree_Bool_tvalid (tvalidB),
        .o_QTree_Bool_tready (tready && !sel),
        .busy                (busyB),
        .error               (errorB)
    );

    qtree_bool_serializer #(.STACK_DEPTH(2)) dutSmall (
        .clk                 (clk),
        .reset               (reset),
        .root_d              (sel ? rootD : 16'h0000),
        .root_r              (rootRS),
        .heap_rd_addr        (rdAddrS),
        .heap_rd_valid       (rdValidS),
        .heap_rd_ready       (rdReady && sel),
        .heap_rsp_data       (rspData),
        .heap_rsp_valid      (rspValid && sel),
        .o_QTree_Bool_tdata  (tdataS),
        .o_QTree_Bool_tlast  (tlastS),
        .o_QTree_Bool_tvalid (tvalidS),
        .o_QTree_Bool_tready (tready && sel),
        .busy                (busyS),
        .error               (errorS)
    );

    assign rootRM   = sel ? rootRS   : rootRB;
    assign rdValidM = sel ? rdValidS : rdValidB;
    assign rdAddrM  = sel ? rdAddrS  : rdAddrB;
    assign tdataM   = sel ? tdataS   : tdataB;
    assign tlastM   = sel ? tlastS   : tlastB;
    assign tvalidM  = sel ? tvalidS  : tvalidB;
    assign busyM    = sel ? busyS    : busyB;
    assign errorM   = sel ? errorS   : errorB;

    int          passed = 0;
    int          total = 0;
    logic [66:0] heapMem [16];
    logic [67:0] beats [$];
    int          readyDelay = 0;
    int          rspDelay = 0;
    int          waitCnt = 0;
    int          rspCnt = -1;
    logic [14:0] curAddr = '0;
    logic [14:0] pendAddr = '0;
    logic        toggleMode = 1'b0;
    logic        holdPending = 1'b0;
    logic [79:0] holdWord = '0;
    vec_t        vecs [NVEC];

    function automatic logic [15:0] ptr(input int a);
        return {a[14:0], 1'b1};
    endfunction

    function automatic logic [66:0] leaf(input int k);
        return {64'(k) + 64'hA0, 2'b00, 1'b1};
    endfunction

    function automatic logic [66:0] qnode(input logic [15:0] c1, input logic [15:0] c2,
                                          input logic [15:0] c3, input logic [15:0] c4);
        return {c4, c3, c2, c1, 2'b10, 1'b0};
    endfunction

    function automatic vec_t mkVec(input int scen, input logic s, input int rd,
                                   input logic tog, input int n, input logic err);
        vec_t v;
        v.scen       = scen;
        v.sel        = s;
        v.readyDelay = rd;
        v.toggle     = tog;
        v.nBeats     = n;
        v.expBeats   = '0;
        v.expErr     = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Heap model: grants a read after readyDelay cycles, answers rspDelay cycles later.
    initial begin
        rdReady  = 1'b0;
        rspValid = 1'b0;
        rspData  = '0;
        forever begin
            @(negedge clk);
            rspValid = 1'b0;
            if (reset) begin
                rdReady = 1'b0;
                waitCnt = 0;
            end else if (rdReady) begin
                rdReady  = 1'b0;
                pendAddr = curAddr;
                rspCnt   = rspDelay;
            end else if (rdValidM === 1'b1) begin
                if (waitCnt >= readyDelay) begin
                    rdReady = 1'b1;
                    curAddr = rdAddrM;
                    waitCnt = 0;
                end else begin
                    waitCnt++;
                end
            end
            if (rspCnt == 0) begin
                rspValid = 1'b1;
                rspData  = heapMem[pendAddr[3:0]];
                rspCnt   = -1;
            end else if (rspCnt > 0) begin
                rspCnt--;
            end
        end
    end

    // Stream collector; a stalled beat must be unchanged one cycle later.
    initial begin
        tready = 1'b1;
        forever begin
            @(negedge clk);
            if (holdPending && !reset)
                check("holdStable", 80'({tvalidM, tlastM, tdataM}), holdWord);
            holdPending = 1'b0;
            tready = toggleMode ? ~tready : 1'b1;
            if (!reset && tvalidM === 1'b1) begin
                if (tready) beats.push_back({tlastM, tdataM});
                else begin
                    holdPending = 1'b1;
                    holdWord    = 80'({1'b1, tlastM, tdataM});
                end
            end
        end
    end

    task automatic loadHeap(input int scen);
        for (int a = 0; a < 16; a++) heapMem[a] = '0;
        for (int a = 2; a <= 5; a++) heapMem[a] = leaf(a);
        case (scen)
            0: heapMem[1] = {64'h1111, 2'b00, 1'b1};
            1: heapMem[1] = qnode(ptr(2), ptr(3), ptr(4), ptr(5));
            2: heapMem[1] = qnode(ptr(2), 16'h0000, ptr(4), ptr(5));
            3: begin
                heapMem[1] = qnode(ptr(2), ptr(3), ptr(4), ptr(6));
                heapMem[6] = qnode(ptr(2), ptr(3), ptr(4), ptr(7));
                heapMem[7] = qnode(ptr(2), ptr(2), ptr(2), ptr(2));
            end
            default: heapMem[1] = {64'hBEEF, 2'b01, 1'b1};
        endcase
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check({tag, " resetState"},
              80'({rootRM, busyM, tvalidM, rdValidM, errorM, tlastM, tdataM}),
              80'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 67'd0}));
        reset = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int cyc = 0;
        while (busyM === 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " finished"}, 80'(cyc < 1000), 80'(1));
        repeat (4) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, input logic withReset, input string tag);
        sel        = v.sel;
        readyDelay = v.readyDelay;
        toggleMode = v.toggle;
        rspDelay   = 0;
        loadHeap(v.scen);
        if (withReset) doReset(tag);
        beats.delete();
        @(negedge clk);
        rootD = 16'h0003;
        @(negedge clk);
        rootD = 16'h0000;
        check({tag, " rootToFetch"}, 80'(rdValidM), 80'(1));
        waitIdle(tag);
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        logic [67:0] act;
        check({tag, " beatCount"}, 80'(beats.size()), 80'(v.nBeats));
        for (int j = 0; j < v.nBeats; j++) begin
            act = (j < beats.size()) ? beats[j] : 68'hx;
            check($sformatf("%s beat%0d", tag, j), 80'(act), 80'(v.expBeats[j]));
        end
        check({tag, " error"}, 80'(errorM), 80'(v.expErr));
        check({tag, " idleAfter"}, 80'({rootRM, busyM, tvalidM}), 80'(3'b100));
    endtask

    task automatic latencySeq(input int scen, input string tag);
        sel = 1'b0;
        readyDelay = 0;
        toggleMode = 1'b0;
        rspDelay = 0;
        loadHeap(scen);
        doReset(tag);
        beats.delete();
        @(negedge clk);
        rootD = 16'h0003;
        @(negedge clk);
        rootD = 16'h0000;
        check({tag, " rdValidAtN1"}, 80'(rdValidM), 80'(1));
        @(negedge clk);
        check({tag, " quietInWait"}, 80'({rdValidM, tvalidM}), 80'(2'b00));
        @(negedge clk);
        if (scen == 0) begin
            check({tag, " leafTvalidAtM1"}, 80'({tvalidM, tlastM}), 80'(2'b11));
        end else begin
            check({tag, " nodeNoReadAtM1"}, 80'({rdValidM, tvalidM}), 80'(2'b00));
            @(negedge clk);
            check({tag, " nodeReadAtM2"}, 80'(rdValidM), 80'(1));
        end
        waitIdle(tag);
        check({tag, " beatCount"}, 80'(beats.size()), 80'((scen == 0) ? 1 : 5));
    endtask

    initial begin
        logic [66:0] rootLeaf, qnoneLeaf, qerr, node1, node2, c1, c2, c3;
        logic        sawActivity;
        rootLeaf  = {64'h1111, 2'b00, 1'b1};
        qnoneLeaf = {64'hBEEF, 2'b01, 1'b1};
        qerr      = {64'h0, 2'b11, 1'b0};
        node1     = qnode(ptr(2), ptr(3), ptr(4), ptr(5));
        node2     = qnode(ptr(2), 16'h0000, ptr(4), ptr(5));
        c1        = qnode(ptr(2), ptr(3), ptr(4), ptr(6));
        c2        = qnode(ptr(2), ptr(3), ptr(4), ptr(7));
        c3        = qnode(ptr(2), ptr(2), ptr(2), ptr(2));

        vecs[0] = mkVec(0, 1'b0, 0, 1'b0, 1, 1'b0);
        vecs[0].expBeats[0] = {1'b1, rootLeaf};
        vecs[1] = mkVec(4, 1'b0, 0, 1'b0, 1, 1'b0);
        vecs[1].expBeats[0] = {1'b1, qnoneLeaf};
        vecs[2] = mkVec(1, 1'b0, 0, 1'b0, 5, 1'b0);
        vecs[2].expBeats[4:0] = {{1'b1, node1}, {1'b0, leaf(2)}, {1'b0, leaf(3)},
                                 {1'b0, leaf(4)}, {1'b0, leaf(5)}};
        vecs[3] = vecs[2];
        vecs[3].readyDelay = 3;
        vecs[3].toggle = 1'b1;
        vecs[4] = mkVec(2, 1'b0, 0, 1'b0, 5, 1'b1);
        vecs[4].expBeats[4:0] = {{1'b1, node2}, {1'b0, leaf(2)}, {1'b0, qerr},
                                 {1'b0, leaf(4)}, {1'b0, leaf(5)}};
        vecs[5] = mkVec(3, 1'b1, 0, 1'b0, 9, 1'b1);
        vecs[5].expBeats[8:0] = {{1'b1, c1}, {1'b0, leaf(2)}, {1'b0, leaf(3)}, {1'b0, leaf(4)},
                                 {1'b0, c2}, {1'b0, leaf(2)}, {1'b0, leaf(3)}, {1'b0, leaf(4)},
                                 {1'b0, qerr}};
        vecs[6] = mkVec(3, 1'b0, 1, 1'b1, 13, 1'b0);
        vecs[6].expBeats[12:0] = {{1'b1, c1}, {1'b0, leaf(2)}, {1'b0, leaf(3)}, {1'b0, leaf(4)},
                                  {1'b0, c2}, {1'b0, leaf(2)}, {1'b0, leaf(3)}, {1'b0, leaf(4)},
                                  {1'b0, c3}, {1'b0, leaf(2)}, {1'b0, leaf(2)}, {1'b0, leaf(2)},
                                  {1'b0, leaf(2)}};

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], 1'b1, $sformatf("vec%0d", i));
            checkOutput(vecs[i], $sformatf("vec%0d", i));
        end

        latencySeq(0, "latLeaf");
        latencySeq(1, "latNode");

        // A root without its valid bit must not start a traversal.
        sawActivity = 1'b0;
        @(negedge clk);
        rootD = 16'h0002;
        repeat (4) begin
            @(negedge clk);
            sawActivity = sawActivity | busyM | rdValidM;
        end
        rootD = 16'h0000;
        check("badRootIgnored", 80'({sawActivity, rootRM}), 80'(2'b01));

        // Reset while waiting on the heap; the late response must be dropped.
        sel = 1'b0;
        readyDelay = 0;
        toggleMode = 1'b0;
        loadHeap(0);
        doReset("rstWait");
        beats.delete();
        rspDelay = 4;
        @(negedge clk);
        rootD = 16'h0003;
        @(negedge clk);
        rootD = 16'h0000;
        @(negedge clk);
        check("rstWait inWait", 80'({busyM, rdValidM, tvalidM}), 80'(3'b100));
        #2 reset = 1'b1;
        #1 check("rstWait asyncIdle", 80'({rootRM, busyM, tvalidM, rdValidM}), 80'(4'b1000));
        @(negedge clk);
        reset = 1'b0;
        sawActivity = 1'b0;
        repeat (10) begin
            @(negedge clk);
            sawActivity = sawActivity | busyM | tvalidM | rdValidM;
        end
        check("rstWait lateRspIgnored", 80'({sawActivity, rootRM, errorM}), 80'(3'b010));
        check("rstWait noBeats", 80'(beats.size()), 80'(0));
        applyStimulus(vecs[0], 1'b0, "rstWait rerun");
        checkOutput(vecs[0], "rstWait rerun");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
